// File: rtl/crc16_serial_checker.sv
// ============================================================================
// Module   : crc16_serial_checker
// Brief    : Serial CRC-16 (0x8005, init 0) codeword checker. It strips the
//            16-bit trailer, emits the message bits and gives a per-frame verdict.
//            Optional good/bad frame counters are enabled by CRC16_STAT_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module crc16_serial_checker #(
    parameter int MAX_BITS = 4096,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_start,
    input  logic             in_bit,
    input  logic             in_last,
    output logic             msg_valid,
    output logic             msg_bit,
    output logic             done,
    output logic             crc_ok,
    output logic             crc_err,
    output logic [15:0]      residue,
    output logic [CNT_W-1:0] bit_count
`ifdef CRC16_STAT_CNT_EN
    ,
    input  logic             stat_clr,
    output logic [15:0]      good_cnt,
    output logic [15:0]      bad_cnt
`endif
);

    localparam logic [15:0]      C_POLY = 16'h8005;
    localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(MAX_BITS);
    localparam logic [CNT_W-1:0] C_MIN  = CNT_W'(17);
    localparam logic [CNT_W-1:0] C_DLY  = CNT_W'(16);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RECV   = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    state_t           r_state, w_state;
    logic [15:0]      r_lfsr, w_lfsr;
    logic [15:0]      r_dly, w_dly;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic             r_msg_valid, w_msg_valid;
    logic             r_msg_bit, w_msg_bit;
    logic             r_done, w_done;
    logic             r_crc_ok, w_crc_ok;
    logic             r_crc_err, w_crc_err;
    logic [15:0]      r_residue, w_residue;

    logic             w_start;
    logic             w_abort;
    logic             w_take;
    logic [15:0]      w_lfsr_base;
    logic [15:0]      w_lfsr_upd;
    logic [CNT_W-1:0] w_cnt_upd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_lfsr      <= '0;
            r_dly       <= '0;
            r_cnt       <= '0;
            r_msg_valid <= 1'b0;
            r_msg_bit   <= 1'b0;
            r_done      <= 1'b0;
            r_crc_ok    <= 1'b0;
            r_crc_err   <= 1'b0;
            r_residue   <= '0;
        end else begin
            r_state     <= w_state;
            r_lfsr      <= w_lfsr;
            r_dly       <= w_dly;
            r_cnt       <= w_cnt;
            r_msg_valid <= w_msg_valid;
            r_msg_bit   <= w_msg_bit;
            r_done      <= w_done;
            r_crc_ok    <= w_crc_ok;
            r_crc_err   <= w_crc_err;
            r_residue   <= w_residue;
        end
    end

    // A start bit always begins a fresh frame from a zero LFSR, even as an abort.
    always_comb begin
        w_state     = r_state;
        w_lfsr      = r_lfsr;
        w_dly       = r_dly;
        w_cnt       = r_cnt;
        w_msg_valid = 1'b0;
        w_msg_bit   = 1'b0;
        w_done      = 1'b0;
        w_crc_ok    = r_crc_ok;
        w_crc_err   = r_crc_err;
        w_residue   = r_residue;

        w_start     = in_valid && in_start;
        w_abort     = w_start && (r_state == S_RECV);
        w_take      = w_start || (in_valid && (r_state == S_RECV));
        w_lfsr_base = w_start ? 16'h0000 : r_lfsr;
        w_lfsr_upd  = {w_lfsr_base[14:0], 1'b0} ^ ((w_lfsr_base[15] ^ in_bit) ? C_POLY : 16'h0000);
        w_cnt_upd   = (w_start ? '0 : r_cnt) + 1'b1;

        if (r_state == S_REPORT) begin
            w_state = S_IDLE;
        end

        if (w_take) begin
            w_state = S_RECV;
            w_lfsr  = w_lfsr_upd;
            w_cnt   = w_cnt_upd;
            w_dly   = {(w_start ? 15'h0000 : r_dly[14:0]), in_bit};
            if (!w_start && (r_cnt >= C_DLY)) begin
                w_msg_valid = 1'b1;
                w_msg_bit   = r_dly[15];
            end
            if (w_start) begin
                w_crc_ok  = 1'b0;
                w_crc_err = 1'b0;
            end
            if (w_abort) begin
                w_done    = 1'b1;
                w_crc_err = 1'b1;
                w_residue = r_lfsr;
            end
            if (in_last || (w_cnt_upd == C_MAX)) begin
                w_state   = S_REPORT;
                w_done    = 1'b1;
                w_residue = w_lfsr_upd;
                w_crc_ok  = in_last && (w_lfsr_upd == 16'h0000) && (w_cnt_upd >= C_MIN) && !w_abort;
                w_crc_err = !w_crc_ok;
            end
        end
    end

    assign msg_valid = r_msg_valid;
    assign msg_bit   = r_msg_bit;
    assign done      = r_done;
    assign crc_ok    = r_crc_ok;
    assign crc_err   = r_crc_err;
    assign residue   = r_residue;
    assign bit_count = r_cnt;

`ifdef CRC16_STAT_CNT_EN
    logic [15:0] r_good_cnt;
    logic [15:0] r_bad_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
        end else if (stat_clr) begin
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
        end else if (r_done) begin
            if (r_crc_ok && (r_good_cnt != 16'hFFFF)) begin
                r_good_cnt <= r_good_cnt + 16'd1;
            end
            if (!r_crc_ok && (r_bad_cnt != 16'hFFFF)) begin
                r_bad_cnt <= r_bad_cnt + 16'd1;
            end
        end
    end

    assign good_cnt = r_good_cnt;
    assign bad_cnt  = r_bad_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_crc16_serial_checker.sv
// ============================================================================
// Module   : tb_crc16_serial_checker
// Brief    : Randomised self-checking bench for crc16_serial_checker, using a
//            polynomial long-division reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_crc16_serial_checker;

    localparam int MAX_BITS = 128;
    localparam int CNT_W    = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_start, in_bit, in_last;
    logic             msg_valid, msg_bit, done, crc_ok, crc_err;
    logic [15:0]      residue;
    logic [CNT_W-1:0] bit_count;
`ifdef CRC16_STAT_CNT_EN
    logic             stat_clr;
    logic [15:0]      good_cnt, bad_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    bit          fr[$];
    bit          exp_msg[$];
    bit          q_msg[$];
    bit          q_ok[$];
    bit          q_err[$];
    logic [15:0] q_res[$];
    logic [15:0] q_cnt[$];

    crc16_serial_checker #(.MAX_BITS(MAX_BITS), .CNT_W(CNT_W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_start  (in_start),
        .in_bit    (in_bit),
        .in_last   (in_last),
        .msg_valid (msg_valid),
        .msg_bit   (msg_bit),
        .done      (done),
        .crc_ok    (crc_ok),
        .crc_err   (crc_err),
        .residue   (residue),
        .bit_count (bit_count)
`ifdef CRC16_STAT_CNT_EN
        ,
        .stat_clr  (stat_clr),
        .good_cnt  (good_cnt),
        .bad_cnt   (bad_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (msg_valid) q_msg.push_back(msg_bit);
        if (done) begin
            q_ok.push_back(crc_ok);
            q_err.push_back(crc_err);
            q_res.push_back(residue);
            q_cnt.push_back(bit_count);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Remainder of (first n bits) * x^16 mod P by textbook long division.
    function automatic logic [15:0] ref_residue(input bit q[$], input int n);
        bit          a[$];
        logic [16:0] p;
        logic [15:0] r;
        p = 17'h18005;
        for (int i = 0; i < n; i++) a.push_back(q[i]);
        for (int i = 0; i < 16; i++) a.push_back(1'b0);
        for (int i = 0; i < n; i++)
            if (a[i])
                for (int j = 0; j <= 16; j++) a[i+j] = a[i+j] ^ p[16-j];
        r = '0;
        for (int j = 0; j < 16; j++) r = {r[14:0], a[n+j]};
        return r;
    endfunction

    function automatic void add_bits(input logic [15:0] v, input int w);
        for (int i = w - 1; i >= 0; i--) fr.push_back(v[i]);
    endfunction

    function automatic void add_ascii(input string s);
        for (int i = 0; i < s.len(); i++) add_bits({8'h00, s[i]}, 8);
    endfunction

    function automatic void build_random(input int nmsg);
        logic [15:0] c;
        fr.delete();
        for (int i = 0; i < nmsg; i++) fr.push_back(1'($urandom));
        c = ref_residue(fr, nmsg);
        add_bits(c, 16);
    endfunction

    // Message bits that a frame of n accepted bits delivers.
    function automatic void add_exp(input int n);
        for (int i = 0; i < n - 16; i++) exp_msg.push_back(fr[i]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input bit b, input bit s, input bit l, input int stall);
        int k;
        k = 0;
        while (k < 6 && $urandom_range(0, 99) < stall) begin
            in_valid = 1'b0;
            in_bit   = 1'($urandom);
            in_start = 1'($urandom);
            in_last  = 1'($urandom);
            tick();
            k++;
        end
        in_valid = 1'b1;
        in_bit   = b;
        in_start = s;
        in_last  = l;
        tick();
        in_valid = 1'b0;
        in_start = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input int stall, input bit with_last);
        for (int i = 0; i < fr.size(); i++)
            send_bit(fr[i], i == 0, with_last && (i == fr.size() - 1), stall);
    endtask

    task automatic wait_done(input string tag, input int target);
        for (int i = 0; i < 8 && q_ok.size() < target; i++) @(negedge clk);
        check({tag, "_ndone"}, q_ok.size(), target);
    endtask

    task automatic expect_verdict(input string tag, input int idx, input bit ok,
                                  input logic [15:0] res, input int cnt, input bit chk_cnt);
        if (idx >= q_ok.size()) begin
            check({tag, "_missing"}, q_ok.size(), idx + 1);
        end else begin
            check({tag, "_ok"}, q_ok[idx], ok);
            check({tag, "_err"}, q_err[idx], !ok);
            check({tag, "_res"}, q_res[idx], res);
            if (chk_cnt) check({tag, "_cnt"}, q_cnt[idx], cnt);
        end
    endtask

    task automatic expect_frame(input string tag, input int idx, input int n, input bit by_last);
        logic [15:0] r;
        r = ref_residue(fr, n);
        expect_verdict(tag, idx, by_last && (r == 16'h0000) && (n >= 17), r, n, 1'b1);
    endtask

    task automatic expect_msgs(input string tag);
        int mism;
        mism = 0;
        check({tag, "_nmsg"}, q_msg.size(), exp_msg.size());
        for (int i = 0; i < q_msg.size() && i < exp_msg.size(); i++)
            if (q_msg[i] != exp_msg[i]) mism++;
        check({tag, "_msgbits"}, mism, 0);
    endtask

    // One whole frame: send, wait for its verdict, compare against the model.
    task automatic run_frame(input string tag, input int stall, input bit with_last, input int n_acc);
        int d0;
        d0 = q_ok.size();
        q_msg.delete();
        exp_msg.delete();
        add_exp(n_acc);
        send_frame(stall, with_last);
        wait_done(tag, d0 + 1);
        expect_frame(tag, d0, n_acc, with_last);
        expect_msgs(tag);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_msg_valid"}, msg_valid, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_crc_ok"}, crc_ok, 0);
        check({tag, "_crc_err"}, crc_err, 0);
        check({tag, "_residue"}, residue, 0);
        check({tag, "_bit_count"}, bit_count, 0);
    endtask

    initial begin
        int          d0;
        logic [15:0] r_old;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_start = 1'b0;
        in_bit   = 1'b0;
        in_last  = 1'b0;
`ifdef CRC16_STAT_CNT_EN
        stat_clr = 1'b0;
`endif
        #23;
        check_zero("reset");
        rst = 1'b1;
        tick();

        // Bits without a start in IDLE must be ignored.
        q_msg.delete();
        for (int i = 0; i < 5; i++) send_bit(1'($urandom), 1'b0, 1'b0, 0);
        repeat (2) tick();
        check("idle_ignore_msgs", q_msg.size(), 0);
        check("idle_ignore_done", q_ok.size(), 0);

        fr.delete(); add_bits(16'h0001, 8); add_bits(16'h8005, 16);
        run_frame("f01", 0, 1'b1, 24);
        expect_verdict("f01_spec", 0, 1'b1, 16'h0000, 24, 1'b1);

        fr.delete(); add_ascii("123456789"); add_bits(16'hFEE8, 16);
        run_frame("ascii", 50, 1'b1, 88);
        expect_verdict("ascii_spec", q_ok.size() - 1, 1'b1, 16'h0000, 88, 1'b1);

        fr[5] = !fr[5];
        run_frame("flip_msg", 50, 1'b1, 88);
        check("flip_msg_res_nz", q_res[q_ok.size() - 1] != 16'h0000, 1);

        fr[5] = !fr[5];
        fr[80] = !fr[80];
        run_frame("flip_crc", 30, 1'b1, 88);
        check("flip_crc_err", q_err[q_ok.size() - 1], 1);

        build_random(0);
        run_frame("crc_only", 20, 1'b1, 16);
        fr.delete(); fr.push_back(1'b1);
        run_frame("one_bit", 0, 1'b1, 1);

        // Abort at bit 30, then a good frame starting at the abort bit.
        build_random(40);
        d0 = q_ok.size();
        q_msg.delete(); exp_msg.delete();
        for (int i = 0; i < 30; i++) send_bit(fr[i], i == 0, 1'b0, 20);
        r_old = ref_residue(fr, 30);
        add_exp(30);
        fr.delete(); add_bits(16'h0001, 8); add_bits(16'h8005, 16);
        add_exp(24);
        send_frame(0, 1'b1);
        wait_done("abort", d0 + 2);
        expect_verdict("abort_old", d0, 1'b0, r_old, 0, 1'b0);
        expect_frame("abort_new", d0 + 1, 24, 1'b1);
        expect_msgs("abort");

        build_random(MAX_BITS - 16);
        run_frame("max_len", 10, 1'b1, MAX_BITS);
        build_random(MAX_BITS);
        run_frame("over_len", 10, 1'b0, MAX_BITS);

        for (int t = 0; t < 6; t++) begin
            build_random($urandom_range(1, MAX_BITS - 16));
            if ($urandom_range(0, 2) == 0) begin
                d0 = $urandom_range(0, fr.size() - 1);
                fr[d0] = !fr[d0];
            end
            run_frame($sformatf("rand%0d", t), $urandom_range(0, 60), 1'b1, fr.size());
        end

        // Back-to-back: second frame starts in the REPORT cycle of the first.
        d0 = q_ok.size();
        q_msg.delete(); exp_msg.delete();
        build_random(20);
        add_exp(36);
        send_frame(0, 1'b1);
        r_old = ref_residue(fr, 36);
        build_random(25);
        fr[3] = !fr[3];
        add_exp(41);
        send_frame(0, 1'b1);
        wait_done("b2b", d0 + 2);
        expect_verdict("b2b_first", d0, 1'b1, r_old, 36, 1'b1);
        expect_frame("b2b_second", d0 + 1, 41, 1'b1);
        expect_msgs("b2b");

        // Asynchronous reset in the middle of a frame.
        build_random(30);
        d0 = q_ok.size();
        for (int i = 0; i < 20; i++) send_bit(fr[i], i == 0, 1'b0, 0);
        rst = 1'b0;
        #1;
        check_zero("midrst");
        repeat (3) tick();
        rst = 1'b1;
        repeat (4) tick();
        check("midrst_no_done", q_ok.size(), d0);

        fr.delete(); add_bits(16'h0001, 8); add_bits(16'h8005, 16);
        run_frame("post_rst", 0, 1'b1, 24);

`ifdef CRC16_STAT_CNT_EN
        repeat (2) tick();
        check("stat_good_after_rst", good_cnt, 1);
        check("stat_bad_after_rst", bad_cnt, 0);
        stat_clr = 1'b1; tick(); stat_clr = 1'b0;
        check("stat_clr_good", good_cnt, 0);
        fr.delete(); fr.push_back(1'b0);
        for (int i = 0; i < 65540; i++) send_frame(0, 1'b1);
        repeat (2) tick();
        check("stat_bad_sat", bad_cnt, 16'hFFFF);
        check("stat_good_zero", good_cnt, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
